// File: rtl/pwm_ramp_ctrl_if.sv
`default_nettype none
//============================================================================
// Module : pwm_ramp_ctrl_if
// Brief  : Command handshake and PWM drive bundle for pwm_ramp_ctrl.
// Rev    : 1.0 - initial release
//============================================================================
interface pwm_ramp_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_freq;
    logic [3:0]       cmd_duty;
    logic [DIV_W-1:0] cmd_step_div;
    logic [3:0]       frequency;
    logic [3:0]       duty_cycle;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_freq, cmd_duty, cmd_step_div,
        input  cmd_ready, frequency, duty_cycle, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_freq, cmd_duty, cmd_step_div,
        output cmd_ready, frequency, duty_cycle, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
//============================================================================
// Module : pwm_ramp_ctrl
// Brief  : Ramps a PWM duty code one step per divider period toward a target.
// Config : PWM_RAMP_ABORT_EN - accept new commands mid-ramp (restart ramp).
// Rev    : 1.0 - initial release
//============================================================================
module pwm_ramp_ctrl #(
    parameter int DIV_W = 8
) (
    input wire             clk,
    input wire             rst,
    pwm_ramp_ctrl_if.slave bus
);

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_RAMP = 2'd1;
    localparam logic [1:0]       c_ST_HOLD = 2'd2;
    localparam logic [DIV_W-1:0] c_DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_freq;
    logic [3:0]       r_duty;
    logic [3:0]       r_target;
    logic [DIV_W-1:0] r_div_reload;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_done;

    logic             w_ready;
    logic             w_busy;
    logic             w_accept;
    logic             w_cmd_match;
    logic             w_step_due;
    logic [3:0]       w_duty_step;

    assign w_accept    = bus.cmd_valid & w_ready;
    assign w_cmd_match = (bus.cmd_duty == r_duty);
    assign w_step_due  = (r_state == c_ST_RAMP) && (r_div_cnt == r_div_reload);
    // Only evaluated in RAMP, where duty never equals target, so no wrap.
    assign w_duty_step = (r_target > r_duty) ? (r_duty + 4'd1) : (r_duty - 4'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an accept always outranks a coincident step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_HOLD: begin
                if (w_accept) begin
                    w_state_nxt = w_cmd_match ? c_ST_HOLD : c_ST_RAMP;
                end
            end
            c_ST_RAMP: begin
                if (w_accept) begin
                    w_state_nxt = w_cmd_match ? c_ST_HOLD : c_ST_RAMP;
                end else if (w_step_due && (w_duty_step == r_target)) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (r_state == c_ST_RAMP) begin
            w_busy = 1'b1;
`ifdef PWM_RAMP_ABORT_EN
            w_ready = 1'b1;
`else
            w_ready = 1'b0;
`endif
        end
    end

    // Datapath: command capture, divider and duty stepping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freq       <= 4'd0;
            r_duty       <= 4'd0;
            r_target     <= 4'd0;
            r_div_reload <= '0;
            r_div_cnt    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_freq       <= bus.cmd_freq;
                r_target     <= bus.cmd_duty;
                r_div_reload <= bus.cmd_step_div;
                r_div_cnt    <= '0;
                r_done       <= w_cmd_match;
            end else if (r_state == c_ST_RAMP) begin
                if (w_step_due) begin
                    r_div_cnt <= '0;
                    r_duty    <= w_duty_step;
                    r_done    <= (w_duty_step == r_target);
                end else begin
                    r_div_cnt <= r_div_cnt + c_DIV_ONE;
                end
            end
        end
    end

    assign bus.cmd_ready  = w_ready;
    assign bus.busy       = w_busy;
    assign bus.frequency  = r_freq;
    assign bus.duty_cycle = r_duty;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
//============================================================================
// Module : tb_pwm_ramp_ctrl
// Brief  : Directed vector table plus multi-cycle sequences for pwm_ramp_ctrl.
// Rev    : 1.0 - initial release
//============================================================================
module tb_pwm_ramp_ctrl;

`ifdef PWM_RAMP_ABORT_EN
    localparam logic c_RR = 1'b1;
`else
    localparam logic c_RR = 1'b0;
`endif

    typedef struct {
        logic       valid;
        logic [3:0] freq;
        logic [3:0] duty;
        logic [7:0] div;
        logic       e_ready;
        logic [3:0] e_freq;
        logic [3:0] e_duty;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   n_done;
    vec_t vecs [16];

    pwm_ramp_ctrl_if #(.DIV_W(8)) bus ();

    pwm_ramp_ctrl #(.DIV_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [3:0] f, input logic [3:0] d,
                                input logic [7:0] dv, input logic er, input logic [3:0] ef,
                                input logic [3:0] ed, input logic eb, input logic edn);
        vec_t t;
        t.valid = v;  t.freq = f;    t.duty = d;    t.div = dv;
        t.e_ready = er; t.e_freq = ef; t.e_duty = ed; t.e_busy = eb; t.e_done = edn;
        return t;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) n_done++;
    endtask

    task automatic drive(input logic v, input logic [3:0] f, input logic [3:0] d, input logic [7:0] dv);
        bus.cmd_valid    = v;
        bus.cmd_freq     = f;
        bus.cmd_duty     = d;
        bus.cmd_step_div = dv;
    endtask

    task automatic wait_duty(input logic [3:0] d, input int budget);
        int k;
        k = 0;
        while (bus.duty_cycle !== d && k < budget) begin
            tick();
            k++;
        end
        chk("wait_duty", 8'(bus.duty_cycle), 8'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0; n_done = 0;
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 8'd0);

        // Up-ramp 0->8 div 0, then down 8->5, then equal-target accept at 5
        vecs[0]  = mk(1'b1, 4'd3, 4'd8, 8'd0, c_RR, 4'd3, 4'd0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd3, 4'd1, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd3, 4'd2, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd3, 4'd3, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd3, 4'd4, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd3, 4'd5, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd3, 4'd6, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd3, 4'd7, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 4'd0, 4'd0, 8'd0, 1'b1, 4'd3, 4'd8, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 4'd0, 4'd0, 8'd0, 1'b1, 4'd3, 4'd8, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 4'd7, 4'd5, 8'd0, c_RR, 4'd7, 4'd8, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd7, 4'd7, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 4'd0, 4'd0, 8'd0, c_RR, 4'd7, 4'd6, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 4'd0, 4'd0, 8'd0, 1'b1, 4'd7, 4'd5, 1'b0, 1'b1);
        vecs[14] = mk(1'b1, 4'd9, 4'd5, 8'd0, 1'b1, 4'd9, 4'd5, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 4'd0, 4'd0, 8'd0, 1'b1, 4'd9, 4'd5, 1'b0, 1'b0);

        // Reset state
        #12;
        chk("rst_freq",  8'(bus.frequency),  8'd0);
        chk("rst_duty",  8'(bus.duty_cycle), 8'd0);
        chk("rst_busy",  8'(bus.busy),       8'd0);
        chk("rst_done",  8'(bus.done),       8'd0);
        chk("rst_ready", 8'(bus.cmd_ready),  8'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].valid, vecs[i].freq, vecs[i].duty, vecs[i].div);
            tick();
            chk($sformatf("v%0d_ready", i), 8'(bus.cmd_ready),  8'(vecs[i].e_ready));
            chk($sformatf("v%0d_freq", i),  8'(bus.frequency),  8'(vecs[i].e_freq));
            chk($sformatf("v%0d_duty", i),  8'(bus.duty_cycle), 8'(vecs[i].e_duty));
            chk($sformatf("v%0d_busy", i),  8'(bus.busy),       8'(vecs[i].e_busy));
            chk($sformatf("v%0d_done", i),  8'(bus.done),       8'(vecs[i].e_done));
        end

        // Down-ramp 8->2 with div 3: one step every 4 cycles
        drive(1'b1, 4'd1, 4'd8, 8'd0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        wait_duty(4'd8, 20);
        tick();
        drive(1'b1, 4'd4, 4'd2, 8'd3);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        chk("dn_freq", 8'(bus.frequency), 8'd4);
        n_done = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk($sformatf("dn%0d_duty", c), 8'(bus.duty_cycle), 8'(8 - c / 4));
            chk($sformatf("dn%0d_busy", c), 8'(bus.busy),       8'(c < 24));
            chk($sformatf("dn%0d_done", c), 8'(bus.done),       8'(c == 24));
        end
        tick();
        chk("dn_done_cnt", 8'(n_done), 8'd1);

        // Abort / no-abort: ramp 0->15 div 1, new command duty 0 at duty 5
        drive(1'b1, 4'd0, 4'd0, 8'd0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        wait_duty(4'd0, 20);
        tick();
        drive(1'b1, 4'd1, 4'd15, 8'd1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        n_done = 0;
        wait_duty(4'd5, 40);
        drive(1'b1, 4'd2, 4'd0, 8'd1);
`ifdef PWM_RAMP_ABORT_EN
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        chk("ab_freq", 8'(bus.frequency),  8'd2);
        chk("ab_hold", 8'(bus.duty_cycle), 8'd5);
        chk("ab_busy", 8'(bus.busy),       8'd1);
        for (int c = 2; c <= 11; c++) begin
            tick();
            chk($sformatf("ab%0d_duty", c), 8'(bus.duty_cycle), 8'(5 - (c - 1) / 2));
            chk($sformatf("ab%0d_done", c), 8'(bus.done),       8'(c == 11));
        end
        tick();
        chk("ab_done_cnt", 8'(n_done), 8'd1);
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("na%0d_duty", c),  8'(bus.duty_cycle), 8'(5 + c / 2));
            chk($sformatf("na%0d_ready", c), 8'(bus.cmd_ready),  8'(c == 20));
            chk($sformatf("na%0d_done", c),  8'(bus.done),       8'(c == 20));
        end
        chk("na_freq_held", 8'(bus.frequency), 8'd1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        chk("na_acc_freq", 8'(bus.frequency),  8'd2);
        chk("na_acc_duty", 8'(bus.duty_cycle), 8'd15);
        chk("na_acc_busy", 8'(bus.busy),       8'd1);
        for (int c = 1; c <= 30; c++) begin
            tick();
            chk($sformatf("nd%0d_duty", c), 8'(bus.duty_cycle), 8'(15 - c / 2));
            chk($sformatf("nd%0d_done", c), 8'(bus.done),       8'(c == 30));
        end
        tick();
        chk("na_done_cnt", 8'(n_done), 8'd2);
`endif

        // Reset mid-ramp at duty 6
        drive(1'b1, 4'd5, 4'd10, 8'd0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        wait_duty(4'd6, 20);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_duty",  8'(bus.duty_cycle), 8'd0);
        chk("mr_freq",  8'(bus.frequency),  8'd0);
        chk("mr_busy",  8'(bus.busy),       8'd0);
        chk("mr_done",  8'(bus.done),       8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_done = 0;
        tick();
        chk("mr_ready", 8'(bus.cmd_ready), 8'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("mr%0d_duty", c), 8'(bus.duty_cycle), 8'd0);
        end
        chk("mr_done_cnt", 8'(n_done), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter DIV_W, default 8: width of the step-interval divider.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port cmd_valid  input  1  command offered.
REQ-006 Port cmd_ready  output  1  command can be accepted; accept = cmd_valid & cmd_ready at a rising edge.
REQ-007 Port cmd_freq  input  4  frequency code, passed to the PWM generator.
REQ-008 Port cmd_duty  input  4  target duty code.
REQ-009 Port cmd_step_div  input  DIV_W  clock cycles between duty steps, minus 1.
REQ-010 Port frequency  output  4  registered, drives the PWM frequency input.
REQ-011 Port duty_cycle  output  4  registered, drives the PWM duty_cycle input.
REQ-012 Port busy  output  1  high while ramping.
REQ-013 Port done  output  1  one-cycle pulse when the target duty is reached.

Function
REQ-014 The FSM SHALL have three states: IDLE (after reset), RAMP and HOLD.
REQ-015 cmd_ready SHALL be combinational from state: 1 in IDLE and HOLD; in RAMP it depends on REQ-027/028.
REQ-016 On accept, these SHALL be registered at that edge: frequency <= cmd_freq, target <= cmd_duty, div_reload <= cmd_step_div, div_cnt <= 0.
REQ-017 On accept with cmd_duty == duty_cycle, the next state SHALL be HOLD and done SHALL be 1 for the following cycle only.
REQ-018 On accept with cmd_duty != duty_cycle, the next state SHALL be RAMP.
REQ-019 In RAMP, div_cnt SHALL increment each cycle.
REQ-020 In RAMP, when div_cnt == div_reload, div_cnt SHALL clear and duty_cycle SHALL step by exactly 1 toward target.
REQ-021 Timing: the first step SHALL appear (div_reload+1) cycles after the accept edge; total ramp = |target - start| * (div_reload+1) cycles.
REQ-022 The step that makes duty_cycle == target SHALL move the FSM to HOLD.
REQ-023 done SHALL be 1 in exactly the first cycle duty_cycle shows target, then 0.
REQ-024 duty_cycle SHALL never wrap or overshoot; values stay within 0..15 and move monotonically toward target.
REQ-025 busy SHALL be 1 iff state == RAMP.
REQ-026 frequency and duty_cycle SHALL hold their values in IDLE and HOLD.

Configuration
REQ-027 With macro PWM_RAMP_ABORT_EN defined:
- cmd_ready SHALL also be 1 in RAMP.
- An accept in RAMP SHALL restart the ramp from the current duty_cycle toward the new target, with div_cnt cleared.
- The aborted ramp SHALL produce no done.
- If the accept coincides with a due step, the accept wins and duty_cycle holds that cycle.
REQ-028 Without PWM_RAMP_ABORT_EN, cmd_ready SHALL be 0 in RAMP, and commands SHALL wait until HOLD.

Reset
REQ-029 While rst is high, outputs SHALL be forced immediately (asynchronously): frequency=0, duty_cycle=0, busy=0, done=0, state=IDLE, div_cnt=0, target=0.
REQ-030 Reset asserted mid-ramp SHALL abandon the ramp with no done pulse; cmd_ready SHALL be 1 from the first cycle after rst is released.

Verification
REQ-031 Up-ramp: after reset, accept freq=F, duty=8, div=0 -> frequency=F next cycle; duty_cycle 1..8 on 8 consecutive cycles; done high with duty=8 only; busy low afterwards.
REQ-032 Down-ramp: from duty=8, accept duty=2, div=3 -> one decrement every 4 cycles, 24 cycles total, single done, busy high throughout.
REQ-033 Equal target: in HOLD at duty=5, accept duty=5 -> busy stays 0; done pulses 1 cycle after the accept; frequency updates to the new code.
REQ-034 Abort, macro defined: ramp 0->15 with div=1; at duty=5 accept duty=0 -> steps down 4,3,2,1,0 every 2 cycles; exactly one done at 0.
REQ-035 No abort, macro undefined: same stimulus -> cmd_ready=0 until duty=15 and HOLD; the held command is then accepted and ramps 15->0.
REQ-036 Reset mid-ramp: assert rst at duty=6 -> duty_cycle=0, frequency=0, busy=0 immediately; no done; cmd_ready=1 after release.
